detector_jogada_debounce: RTL and testbench
===========================================

// Module: detector_jogada_debounce
// PURPOSE
//  Upstream input stage of the memory-game datapath: conditions the raw slide/push
//  keys (chaves) before they reach the play register and comparator.
//  Synchronises, debounces and validates each key press; emits a clean registered
//  jogada plus a one-cycle jogada_feita pulse per press.
//  Multi-key presses are flagged with jogada_invalida instead of jogada_feita.
//  db_estado drives a hexa7seg debug display.
// PARAMETERS
//  N               4      key/play width in bits
//  DEBOUNCE_CYCLES 50000  stable cycles required on press and on release (>=2); 1 ms @ 50 MHz
// PORTS
//  clock            in   1  system clock, rising edge
//  reset            in   1  asynchronous, active-high; forces all state/outputs to reset values
//  chaves           in   N  raw asynchronous keys, active-high
//  habilita         in   1  control unit accepts a new play; sampled only in OCIOSO
//  zera             in   1  synchronous clear; priority over everything except reset
//  jogada           out  N  last valid one-hot play (registered)
//  jogada_feita     out  1  one-cycle pulse: valid play captured in jogada
//  jogada_invalida  out  1  one-cycle pulse: debounced press was 0 or >1 keys
//  db_estado        out  4  current FSM state code
// BEHAVIOUR
//  Reset (async) and zera (sync): state=OCIOSO, jogada=0, counter=0, sample=0,
//    pulses=0, synchroniser FFs=0 (reset only; zera leaves synchroniser running).
//  Sync: 2-FF synchroniser on chaves -> cs; FSM sees only cs.
//  Counter width $clog2(DEBOUNCE_CYCLES); never wraps, cleared on every state entry.
//  States (db_estado code):
//   OCIOSO(0): if habilita && cs!=0 -> ESTABILIZA, sample<=cs, cnt<=0; else stay.
//   ESTABILIZA(1): cs==0 -> OCIOSO (bounce); cs!=sample -> sample<=cs, cnt<=0;
//     else cnt==DEBOUNCE_CYCLES-1 -> VALIDA, else cnt++.
//     On entry to VALIDA: if sample one-hot, jogada<=sample; else jogada unchanged.
//   VALIDA(2), one cycle, Moore outputs: jogada_feita=onehot(sample),
//     jogada_invalida=!onehot(sample); always -> ESPERA_SOLTAR.
//   ESPERA_SOLTAR(3): cs==0 -> SOLTANDO, cnt<=0; else stay (key held: no repeat).
//   SOLTANDO(4): cs!=0 -> ESPERA_SOLTAR; cnt==DEBOUNCE_CYCLES-1 -> OCIOSO; else cnt++.
//   Unused codes -> OCIOSO.
//  Latency: chaves stable from edge 0 (first ff1 capture): jogada_feita high exactly
//    in the cycle after edge DEBOUNCE_CYCLES+2; jogada valid same cycle and held.
//  At most one pulse (feita or invalida) per press; never both in one cycle.
//  habilita low in OCIOSO: presses ignored; a key already held when habilita rises
//    is accepted (starts ESTABILIZA). habilita dropping after OCIOSO does not abort.
//  Bounce shorter than DEBOUNCE_CYCLES on press or release: no pulse, no repeat.
//  Key change to another non-zero value during ESTABILIZA restarts count with new sample.
//  zera and press simultaneous: zera wins, no pulse that cycle.
//  reset mid-operation: immediate OCIOSO, jogada=0, no pulse until a full new press.
// TESTING (DEBOUNCE_CYCLES=4, N=4)
//  1 clean press: habilita=1, chaves=0100 from edge 0 -> jogada_feita=1 only in cycle after
//    edge 6, jogada=0100, jogada_invalida=0; db_estado 0->1->2->3.
//  2 bounce: chaves 0010 for 2 cycles, 0 for 2, 0010 held -> exactly one pulse, jogada=0010.
//  3 hold+release: hold 1000 for 30 cycles then release 0 -> one pulse; db_estado 3,4,0;
//    second press after idle -> second pulse.
//  4 invalid: chaves=0110 held -> jogada_invalida one cycle, jogada_feita=0, jogada unchanged.
//  5 habilita=0 with press 0001 -> no pulses, db_estado stays 0; raise habilita while held
//    -> pulse D+1 cycles after habilita rises.
//  6 reset asserted async while in ESTABILIZA, and zera in VALIDA -> outputs 0 immediately /
//    next edge, db_estado=0, no pulse.

Source files
------------

// File: rtl/detector_jogada_debounce.sv
// detector_jogada_debounce
//   Input stage of the memory-game datapath. Synchronises the raw keys,
//   debounces press and release, checks that exactly one key is down and
//   emits a registered play plus a one-cycle pulse per press.
//
// Ports
//   clock           in  1  system clock, rising edge
//   reset           in  1  asynchronous active-high reset
//   chaves          in  N  raw asynchronous keys, active-high
//   habilita        in  1  new play accepted (sampled only while idle)
//   zera            in  1  synchronous clear, priority below reset only
//   jogada          out N  last valid one-hot play (registered)
//   jogada_feita    out 1  one-cycle pulse, valid play captured
//   jogada_invalida out 1  one-cycle pulse, press had zero or several keys
//   db_estado       out 4  current FSM state code for debug display
module detector_jogada_debounce #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] chaves,
  input  logic         habilita,
  input  logic         zera,
  output logic [N-1:0] jogada,
  output logic         jogada_feita,
  output logic         jogada_invalida,
  output logic [3:0]   db_estado
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    ESTABILIZA    = 3'd1,
    VALIDA        = 3'd2,
    ESPERA_SOLTAR = 3'd3,
    SOLTANDO      = 3'd4
  } estado_t;

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_cs;
  estado_t       r_estado;
  estado_t       w_prox_estado;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [N-1:0]  r_amostra;
  logic [N-1:0]  w_amostra_nxt;
  logic [N-1:0]  r_jogada;
  logic [N-1:0]  w_jogada_nxt;
  logic          w_cs_ativo;
  logic          w_amostra_onehot;

  // Two-flop synchroniser; zera intentionally leaves it running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_cs    <= '0;
    end else begin
      r_sync1 <= chaves;
      r_cs    <= r_sync1;
    end
  end

  assign w_cs_ativo       = |r_cs;
  assign w_amostra_onehot = $onehot(r_amostra);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_cnt     <= '0;
      r_amostra <= '0;
      r_jogada  <= '0;
    end else begin
      r_estado  <= w_prox_estado;
      r_cnt     <= w_cnt_nxt;
      r_amostra <= w_amostra_nxt;
      r_jogada  <= w_jogada_nxt;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_cnt_nxt     = r_cnt;
    w_amostra_nxt = r_amostra;
    w_jogada_nxt  = r_jogada;
    if (zera) begin
      w_prox_estado = OCIOSO;
      w_cnt_nxt     = '0;
      w_amostra_nxt = '0;
      w_jogada_nxt  = '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (habilita && w_cs_ativo) begin
            w_prox_estado = ESTABILIZA;
            w_amostra_nxt = r_cs;
            w_cnt_nxt     = '0;
          end
        end
        ESTABILIZA: begin
          if (!w_cs_ativo) begin
            w_prox_estado = OCIOSO;
            w_cnt_nxt     = '0;
          end else if (r_cs != r_amostra) begin
            // Key pattern changed: restart the stability window on the new value.
            w_amostra_nxt = r_cs;
            w_cnt_nxt     = '0;
          end else if (r_cnt == CNT_MAX) begin
            w_prox_estado = VALIDA;
            w_cnt_nxt     = '0;
            if (w_amostra_onehot) begin
              w_jogada_nxt = r_amostra;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        VALIDA: begin
          w_prox_estado = ESPERA_SOLTAR;
          w_cnt_nxt     = '0;
        end
        ESPERA_SOLTAR: begin
          if (!w_cs_ativo) begin
            w_prox_estado = SOLTANDO;
            w_cnt_nxt     = '0;
          end
        end
        SOLTANDO: begin
          if (w_cs_ativo) begin
            w_prox_estado = ESPERA_SOLTAR;
            w_cnt_nxt     = '0;
          end else if (r_cnt == CNT_MAX) begin
            w_prox_estado = OCIOSO;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_prox_estado = OCIOSO;
          w_cnt_nxt     = '0;
        end
      endcase
    end
  end

  // Pulses are Moore outputs of VALIDA, masked by zera so a clear in the
  // same cycle never lets a pulse escape.
  always_comb begin
    jogada_feita    = 1'b0;
    jogada_invalida = 1'b0;
    if (r_estado == VALIDA && !zera) begin
      jogada_feita    = w_amostra_onehot;
      jogada_invalida = !w_amostra_onehot;
    end
  end

  assign jogada    = r_jogada;
  assign db_estado = {1'b0, r_estado};

endmodule

// File: tb/tb_detector_jogada_debounce.sv
module tb_detector_jogada_debounce;
  localparam int N = 4;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] chaves = '0;
  logic         habilita = 1'b0;
  logic         zera = 1'b0;
  logic [N-1:0] jogada;
  logic         jogada_feita;
  logic         jogada_invalida;
  logic [3:0]   db_estado;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    bit         feita;
    logic [3:0] jog;
    int         edge_n;
  } exp_t;

  exp_t sb[$];

  detector_jogada_debounce #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock),
    .reset(reset),
    .chaves(chaves),
    .habilita(habilita),
    .zera(zera),
    .jogada(jogada),
    .jogada_feita(jogada_feita),
    .jogada_invalida(jogada_invalida),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  // Pulse monitor: every pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (jogada_feita && jogada_invalida) begin
      checks++; failures++;
      $display("FAIL both_pulses edge=%0d feita=%b invalida=%b required=not both", edge_cnt, jogada_feita, jogada_invalida);
    end else if (jogada_feita || jogada_invalida) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse edge=%0d feita=%b invalida=%b jogada=%b required=no pulse", edge_cnt, jogada_feita, jogada_invalida, jogada);
      end else begin
        e = sb.pop_front();
        if (jogada_feita !== e.feita) begin
          failures++;
          $display("FAIL pulse_kind edge=%0d feita=%b required=%b", edge_cnt, jogada_feita, e.feita);
        end
        if (jogada !== e.jog) begin
          failures++;
          $display("FAIL pulse_jogada edge=%0d jogada=%b required=%b", edge_cnt, jogada, e.jog);
        end
        if (e.edge_n >= 0 && edge_cnt != e.edge_n) begin
          failures++;
          $display("FAIL pulse_latency edge=%0d required=%0d", edge_cnt, e.edge_n);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push_exp(input bit feita, input logic [3:0] jog, input int edge_n);
    exp_t e;
    e.feita = feita; e.jog = jog; e.edge_n = edge_n;
    sb.push_back(e);
  endtask

  task automatic wait_state(input logic [3:0] code, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (db_estado == code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sb(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) sb.delete();
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks += 4;
    if (jogada !== 4'b0000) begin failures++; $display("FAIL reset_jogada got=%b required=0000", jogada); end
    if (jogada_feita !== 1'b0) begin failures++; $display("FAIL reset_feita got=%b required=0", jogada_feita); end
    if (jogada_invalida !== 1'b0) begin failures++; $display("FAIL reset_invalida got=%b required=0", jogada_invalida); end
    if (db_estado !== 4'd0) begin failures++; $display("FAIL reset_estado got=%0d required=0", db_estado); end
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  task automatic release_idle(input string name);
    bit ok;
    chaves = '0;
    wait_state(4'd0, 30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_idle estado=%0d required=0 within 30 cycles", name, db_estado); end
    step(1);
  endtask

  task automatic test_clean_press;
    int e0;
    logic [3:0] exp_st;
    step(1);
    habilita = 1'b1;
    chaves = 4'b0100;
    e0 = edge_cnt + 1;
    push_exp(1'b1, 4'b0100, e0 + D + 2);
    for (int k = 0; k <= D + 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k < 2) exp_st = 4'd0;
      else if (k < D + 2) exp_st = 4'd1;
      else if (k == D + 2) exp_st = 4'd2;
      else exp_st = 4'd3;
      checks++;
      if (db_estado !== exp_st) begin failures++; $display("FAIL clean_estado k=%0d got=%0d required=%0d", k, db_estado, exp_st); end
      if (k == D + 2) begin
        checks++;
        if (jogada !== 4'b0100) begin failures++; $display("FAIL clean_jogada got=%b required=0100", jogada); end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL clean_pending got=%0d required=0", sb.size()); sb.delete(); end
    release_idle("clean");
  endtask

  task automatic test_bounce;
    int e1;
    bit ok;
    chaves = 4'b0010;
    step(2);
    chaves = 4'b0000;
    step(2);
    chaves = 4'b0010;
    e1 = edge_cnt + 1;
    push_exp(1'b1, 4'b0010, e1 + D + 2);
    wait_sb(20, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL bounce_pulse got=none required=one pulse"); end
    if (jogada !== 4'b0010) begin failures++; $display("FAIL bounce_jogada got=%b required=0010", jogada); end
    step(5);
    release_idle("bounce");
  endtask

  task automatic test_hold_release;
    int e0;
    int r;
    bit ok;
    logic [3:0] exp_st;
    chaves = 4'b1000;
    e0 = edge_cnt + 1;
    push_exp(1'b1, 4'b1000, e0 + D + 2);
    step(30);
    checks += 2;
    if (sb.size() != 0) begin failures++; $display("FAIL hold_pulse got=none required=one pulse"); sb.delete(); end
    if (db_estado !== 4'd3) begin failures++; $display("FAIL hold_estado got=%0d required=3", db_estado); end
    chaves = 4'b0000;
    r = edge_cnt + 1;
    for (int k = 0; k <= D + 2; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k < 2) exp_st = 4'd3;
      else if (k < D + 2) exp_st = 4'd4;
      else exp_st = 4'd0;
      checks++;
      if (db_estado !== exp_st) begin failures++; $display("FAIL release_estado k=%0d got=%0d required=%0d", k, db_estado, exp_st); end
    end
    step(3);
    chaves = 4'b1000;
    e0 = edge_cnt + 1;
    push_exp(1'b1, 4'b1000, e0 + D + 2);
    wait_sb(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL second_press got=none required=one pulse (r=%0d)", r); end
    release_idle("hold");
  endtask

  task automatic test_invalid;
    int e0;
    bit ok;
    chaves = 4'b0110;
    e0 = edge_cnt + 1;
    push_exp(1'b0, 4'b1000, e0 + D + 2);
    wait_sb(20, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL invalid_pulse got=none required=invalida"); end
    if (jogada !== 4'b1000) begin failures++; $display("FAIL invalid_jogada got=%b required=1000", jogada); end
    release_idle("invalid");
  endtask

  task automatic test_habilita;
    int h;
    bit ok;
    habilita = 1'b0;
    chaves = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      checks++;
      if (db_estado !== 4'd0) begin failures++; $display("FAIL hab_idle k=%0d got=%0d required=0", k, db_estado); end
    end
    @(posedge clock); #2;
    habilita = 1'b1;
    h = edge_cnt + 1;
    push_exp(1'b1, 4'b0001, h + D);
    step(1);
    habilita = 1'b0;
    wait_sb(20, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL hab_pulse got=none required=one pulse"); end
    if (jogada !== 4'b0001) begin failures++; $display("FAIL hab_jogada got=%b required=0001", jogada); end
    release_idle("hab");
    habilita = 1'b1;
  endtask

  task automatic test_reset_mid;
    int e0;
    bit ok;
    chaves = 4'b0010;
    wait_state(4'd1, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_reach_estabiliza got=%0d required=1", db_estado); end
    #3 reset = 1'b1;
    #1;
    checks += 3;
    if (db_estado !== 4'd0) begin failures++; $display("FAIL rst_async_estado got=%0d required=0", db_estado); end
    if (jogada !== 4'b0000) begin failures++; $display("FAIL rst_async_jogada got=%b required=0000", jogada); end
    if (jogada_feita !== 1'b0) begin failures++; $display("FAIL rst_async_feita got=%b required=0", jogada_feita); end
    step(2);
    reset = 1'b0;
    e0 = edge_cnt + 1;
    push_exp(1'b1, 4'b0010, e0 + D + 2);
    step(3);
    checks++;
    if (jogada !== 4'b0000) begin failures++; $display("FAIL rst_hold_jogada got=%b required=0000", jogada); end
    wait_sb(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_new_press got=none required=one pulse"); end
    release_idle("rst");
  endtask

  task automatic test_zera;
    chaves = 4'b0100;
    step(D + 3);
    zera = 1'b1;
    @(negedge clock);
    checks += 4;
    if (db_estado !== 4'd2) begin failures++; $display("FAIL zera_in_valida got=%0d required=2", db_estado); end
    if (jogada_feita !== 1'b0) begin failures++; $display("FAIL zera_feita got=%b required=0", jogada_feita); end
    if (jogada_invalida !== 1'b0) begin failures++; $display("FAIL zera_invalida got=%b required=0", jogada_invalida); end
    if (jogada !== 4'b0100) begin failures++; $display("FAIL zera_loaded got=%b required=0100", jogada); end
    @(negedge clock);
    checks += 2;
    if (db_estado !== 4'd0) begin failures++; $display("FAIL zera_estado got=%0d required=0", db_estado); end
    if (jogada !== 4'b0000) begin failures++; $display("FAIL zera_jogada got=%b required=0000", jogada); end
    step(3);
    checks++;
    if (db_estado !== 4'd0) begin failures++; $display("FAIL zera_held got=%0d required=0", db_estado); end
    chaves = 4'b0000;
    step(3);
    zera = 1'b0;
    step(3);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL zera_pending got=%0d required=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_release();
    test_invalid();
    test_habilita();
    test_reset_mid();
    test_zera();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish before 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
